// File: rtl/pcap_mem_store_framer.sv
// Prefixes every packet with a 256-bit descriptor word and forwards the data beats unchanged.
// Keeps packet, output-word and length-error counters for the register interface.
module pcap_mem_store_framer #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axis_aclk,
  input  logic                              axis_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              store_en,
  input  logic                              stat_clear,
  output logic [31:0]                       stat_pkt_count,
  output logic [31:0]                       stat_word_count,
  output logic [15:0]                       stat_len_err_count
);

  localparam int unsigned KeepW = C_M_AXIS_DATA_WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e                           state_q, state_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   data_q, data_d;
  logic [KeepW-1:0]                 keep_q, keep_d;
  logic                             last_q, last_d;
  logic                             valid_q, valid_d;
  logic [15:0]                      len_q, len_d;
  logic [31:0]                      acc_q, acc_d;
  logic [31:0]                      pkt_q, pkt_d;
  logic [31:0]                      word_q, word_d;
  logic [15:0]                      err_q, err_d;

  logic                             slot_free;
  logic                             in_hs;
  logic                             last_hs;
  logic                             out_hs;
  logic [31:0]                      beat_bytes;
  logic [31:0]                      total_bytes;
  logic [16:0]                      len_rnd;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   header;

  logic unused_tuser;
  assign unused_tuser = ^{s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:64], s_axis_tuser[31:16],
                          len_rnd[16]};

  function automatic logic [31:0] popcount(input logic [KeepW-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < int'(KeepW); i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

  assign slot_free   = !valid_q || m_axis_tready;
  assign out_hs      = valid_q && m_axis_tready;
  assign in_hs       = (state_q == StData) && s_axis_tvalid && slot_free;
  assign last_hs     = in_hs && s_axis_tlast;
  assign beat_bytes  = popcount(s_axis_tkeep);
  assign total_bytes = acc_q + beat_bytes;
  assign len_rnd     = {1'b0, s_axis_tuser[15:0]} + 17'd31;

  always_comb begin
    header            = '0;
    header[15:0]      = s_axis_tuser[15:0];
    header[26:16]     = len_rnd[15:5];
    header[63:32]     = s_axis_tuser[63:32];
    header[95:64]     = pkt_q;
    header[255:224]   = 32'hCAFE_0001;
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    keep_d        = keep_q;
    last_d        = last_q;
    valid_d       = valid_q;
    len_d         = len_q;
    acc_d         = acc_q;
    s_axis_tready = 1'b0;

    // A free slot empties unless something is loaded below in the same cycle.
    if (slot_free) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (s_axis_tvalid && store_en && slot_free) begin
          data_d  = header;
          keep_d  = '1;
          last_d  = 1'b0;
          valid_d = 1'b1;
          len_d   = s_axis_tuser[15:0];
          acc_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        s_axis_tready = slot_free;
        if (in_hs) begin
          data_d  = s_axis_tdata;
          keep_d  = s_axis_tkeep;
          last_d  = s_axis_tlast;
          valid_d = 1'b1;
          acc_d   = total_bytes;
          if (s_axis_tlast) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pkt_d  = pkt_q;
    word_d = word_q;
    err_d  = err_q;
    if (out_hs) begin
      word_d = word_q + 32'd1;
    end
    if (last_hs) begin
      pkt_d = pkt_q + 32'd1;
      if ((total_bytes != {16'd0, len_q}) && (err_q != 16'hFFFF)) begin
        err_d = err_q + 16'd1;
      end
    end
    // Clear wins over a coincident increment.
    if (stat_clear) begin
      pkt_d  = '0;
      word_d = '0;
      err_d  = '0;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q <= StIdle;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      len_q   <= '0;
      acc_q   <= '0;
      pkt_q   <= '0;
      word_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      pkt_q   <= pkt_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign m_axis_tdata       = data_q;
  assign m_axis_tkeep       = keep_q;
  assign m_axis_tlast       = last_q;
  assign m_axis_tvalid      = valid_q;
  assign stat_pkt_count     = pkt_q;
  assign stat_word_count    = word_q;
  assign stat_len_err_count = err_q;

endmodule

// File: tb/tb_pcap_mem_store_framer.sv
// Directed bench for pcap_mem_store_framer: framing, backpressure, back-to-back packets,
// length errors, store_en gating, counter clear and mid-packet reset.
module tb_pcap_mem_store_framer;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } word_t;

  logic         clk = 1'b0;
  logic         axis_areset;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         store_en;
  logic         stat_clear;
  logic [31:0]  pkt_cnt;
  logic [31:0]  word_cnt;
  logic [15:0]  err_cnt;

  logic ready_base;
  logic toggle_en;
  logic pat_ready;
  assign m_tready = toggle_en ? pat_ready : ready_base;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  word_t got[$];
  int    got_cyc[$];
  word_t exp[$];
  int    got_rd = 0;
  int    exp_rd = 0;
  int    span_cyc = 0;
  int    stall_bad = 0;
  logic  stalled = 1'b0;
  word_t held;

  always #5 clk = ~clk;

  pcap_mem_store_framer dut (
    .axis_aclk         (clk),
    .axis_areset       (axis_areset),
    .s_axis_tdata      (s_tdata),
    .s_axis_tkeep      (s_tkeep),
    .s_axis_tuser      (s_tuser),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tlast      (s_tlast),
    .m_axis_tdata      (m_tdata),
    .m_axis_tkeep      (m_tkeep),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tlast      (m_tlast),
    .store_en          (store_en),
    .stat_clear        (stat_clear),
    .stat_pkt_count    (pkt_cnt),
    .stat_word_count   (word_cnt),
    .stat_len_err_count(err_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern 1,0,0,1 repeating while toggling is enabled.
  initial begin
    int k;
    k = 0;
    pat_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        pat_ready = ((k % 4) == 0) || ((k % 4) == 3);
        k++;
      end else begin
        pat_ready = 1'b1;
      end
    end
  end

  // Output monitor: records handshakes and notes any change while stalled.
  always @(negedge clk) begin
    if (m_tvalid) begin
      if (stalled && ({m_tdata, m_tkeep, m_tlast} !== held)) stall_bad++;
      if (m_tready) begin
        got.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast});
        got_cyc.push_back(cyc);
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = '{d: m_tdata, k: m_tkeep, l: m_tlast};
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] hdr_word(input logic [15:0] len, input logic [10:0] beats,
                                            input logic [31:0] ts, input logic [31:0] seq);
    logic [255:0] h;
    h = {32'hCAFE_0001, 128'd0, seq, ts, 5'd0, beats, len};
    return h;
  endfunction

  function automatic logic [255:0] beat_data(input int p, input int b);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(p * 4096 + b * 16 + i) ^ 32'h5A00_0000;
    return d;
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u,
                           input logic l);
    int n;
    s_tdata  = d;
    s_tkeep  = k;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 60) begin
        chk("input handshake timeout", 256'd0, 256'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Queues the hand-computed header plus pass-through beats, then drives the packet.
  task automatic send_pkt(input int p, input int nbytes, input logic [15:0] len,
                          input logic [10:0] beats, input logic [31:0] ts,
                          input logic [31:0] seq);
    int nb;
    int rem;
    logic [31:0] keep;
    nb = (nbytes + 31) / 32;
    exp.push_back('{d: hdr_word(len, beats, ts, seq), k: 32'hFFFF_FFFF, l: 1'b0});
    for (int b = 0; b < nb; b++) begin
      rem  = nbytes - 32 * b;
      keep = (rem >= 32) ? 32'hFFFF_FFFF : ((32'd1 << rem) - 32'd1);
      exp.push_back('{d: beat_data(p, b), k: keep, l: (b == nb - 1)});
      send_beat(beat_data(p, b), keep, {64'd0, ts, 16'd0, len}, (b == nb - 1));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    int ng;
    int ne;
    n = 0;
    while (((got.size() - got_rd) < (exp.size() - exp_rd)) && (n < 80)) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    ng = got.size() - got_rd;
    ne = exp.size() - exp_rd;
    chk({tag, " word count"}, 256'(ng), 256'(ne));
    for (int i = 0; i < ng && i < ne; i++) begin
      chk($sformatf("%s w%0d data", tag, i), got[got_rd + i].d, exp[exp_rd + i].d);
      chk($sformatf("%s w%0d keep", tag, i), 256'(got[got_rd + i].k), 256'(exp[exp_rd + i].k));
      chk($sformatf("%s w%0d last", tag, i), 256'(got[got_rd + i].l), 256'(exp[exp_rd + i].l));
    end
    span_cyc = (ng > 0) ? (got_cyc[got.size() - 1] - got_cyc[got_rd]) : -1;
    got_rd = got.size();
    exp_rd = exp.size();
  endtask

  task automatic chk_stats(input string tag, input int p, input int w, input int e);
    @(negedge clk);
    chk({tag, " pkt_count"}, 256'(pkt_cnt), 256'(p));
    chk({tag, " word_count"}, 256'(word_cnt), 256'(w));
    chk({tag, " len_err_count"}, 256'(err_cnt), 256'(e));
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 stat_clear = 1'b1;
    @(posedge clk);
    #1 stat_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_areset = 1'b1;
    s_tdata     = '0;
    s_tkeep     = '0;
    s_tuser     = '0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    store_en    = 1'b1;
    stat_clear  = 1'b0;
    ready_base  = 1'b1;
    toggle_en   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset m_tvalid", 256'(m_tvalid), 256'd0);
    chk("reset m_tlast", 256'(m_tlast), 256'd0);
    chk("reset m_tdata", m_tdata, 256'd0);
    chk("reset m_tkeep", 256'(m_tkeep), 256'd0);
    chk("reset s_tready", 256'(s_tready), 256'd0);
    chk("reset pkt_count", 256'(pkt_cnt), 256'd0);
    chk("reset word_count", 256'(word_cnt), 256'd0);
    chk("reset len_err_count", 256'(err_cnt), 256'd0);
    @(posedge clk);
    #1 axis_areset = 1'b0;

    // 60-byte packet, no backpressure.
    send_pkt(1, 60, 16'd60, 11'd2, 32'h100, 32'd0);
    s_tvalid = 1'b0;
    drain("pkt60");
    chk_stats("pkt60", 1, 3, 0);

    // Same packet under toggling backpressure.
    pulse_clear();
    toggle_en = 1'b1;
    send_pkt(2, 60, 16'd60, 11'd2, 32'h100, 32'd0);
    s_tvalid = 1'b0;
    drain("stall");
    toggle_en = 1'b0;
    chk("stall output stability", 256'(stall_bad), 256'd0);
    chk_stats("stall", 1, 3, 0);

    // Three back-to-back 64-byte packets.
    pulse_clear();
    send_pkt(3, 64, 16'd64, 11'd2, 32'h10, 32'd0);
    send_pkt(4, 64, 16'd64, 11'd2, 32'h20, 32'd1);
    send_pkt(5, 64, 16'd64, 11'd2, 32'h30, 32'd2);
    s_tvalid = 1'b0;
    drain("b2b");
    chk("b2b span cycles", 256'(span_cyc), 256'd8);
    chk_stats("b2b", 3, 9, 0);

    // Declared length 100, only 64 bytes delivered.
    send_pkt(6, 64, 16'd100, 11'd4, 32'h40, 32'd3);
    s_tvalid = 1'b0;
    drain("lenerr");
    chk_stats("lenerr", 4, 12, 1);

    // store_en gating, then drop store_en mid-packet.
    store_en = 1'b0;
    exp.push_back('{d: hdr_word(16'd40, 11'd2, 32'h55, 32'd4), k: 32'hFFFF_FFFF, l: 1'b0});
    exp.push_back('{d: beat_data(7, 0), k: 32'hFFFF_FFFF, l: 1'b0});
    exp.push_back('{d: beat_data(7, 1), k: 32'h0000_00FF, l: 1'b1});
    s_tdata  = beat_data(7, 0);
    s_tkeep  = 32'hFFFF_FFFF;
    s_tuser  = {64'd0, 32'h55, 16'd0, 16'd40};
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("gated s_tready", 256'(s_tready), 256'd0);
    chk("gated m_tvalid", 256'(m_tvalid), 256'd0);
    @(posedge clk);
    #1 store_en = 1'b1;
    @(negedge clk);
    chk("enable same-cycle m_tvalid", 256'(m_tvalid), 256'd0);
    @(posedge clk);
    #1 store_en = 1'b0;
    @(negedge clk);
    chk("enable next-cycle m_tvalid", 256'(m_tvalid), 256'd1);
    chk("enable next-cycle header", m_tdata, hdr_word(16'd40, 11'd2, 32'h55, 32'd4));
    chk("enable data s_tready", 256'(s_tready), 256'd1);
    @(posedge clk);
    #1;
    send_beat(beat_data(7, 1), 32'h0000_00FF, {64'd0, 32'h55, 16'd0, 16'd40}, 1'b1);
    s_tvalid = 1'b0;
    drain("store_en");
    chk_stats("store_en", 5, 15, 1);
    store_en = 1'b1;

    // Counter clear after two packets; next header restarts at sequence 0.
    send_pkt(8, 32, 16'd32, 11'd1, 32'h61, 32'd5);
    send_pkt(9, 32, 16'd32, 11'd1, 32'h62, 32'd6);
    s_tvalid = 1'b0;
    drain("preclear");
    chk_stats("preclear", 7, 19, 1);
    pulse_clear();
    chk_stats("cleared", 0, 0, 0);
    send_pkt(10, 32, 16'd32, 11'd1, 32'h63, 32'd0);
    s_tvalid = 1'b0;
    drain("postclear");
    chk_stats("postclear", 1, 2, 0);

    // Reset in the middle of a packet.
    ready_base = 1'b0;
    s_tdata  = beat_data(11, 0);
    s_tkeep  = 32'hFFFF_FFFF;
    s_tuser  = {64'd0, 32'h70, 16'd0, 16'd64};
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1 ready_base = 1'b1;
    @(negedge clk);
    chk("pre-reset m_tvalid", 256'(m_tvalid), 256'd1);
    chk("pre-reset s_tready", 256'(s_tready), 256'd1);
    #1 axis_areset = 1'b1;
    #1;
    chk("mid-reset m_tvalid", 256'(m_tvalid), 256'd0);
    chk("mid-reset s_tready", 256'(s_tready), 256'd0);
    chk("mid-reset m_tdata", m_tdata, 256'd0);
    chk("mid-reset pkt_count", 256'(pkt_cnt), 256'd0);
    s_tvalid = 1'b0;
    @(posedge clk);
    #1 axis_areset = 1'b0;
    got_rd = got.size();
    exp_rd = exp.size();

    // Zero declared length with 32 bytes present.
    send_pkt(12, 32, 16'd0, 11'd0, 32'h80, 32'd0);
    s_tvalid = 1'b0;
    drain("len0");
    chk_stats("len0", 1, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcap_mem_store_framer.md
# pcap_mem_store_framer

The framer sits directly downstream of the pcap pre-store stage, on the path from host DMA into external memory. It receives 256-bit AXI4-Stream packets whose tuser already carries the packet length and the inter-packet timestamp. For each packet it emits one 256-bit descriptor (header) word followed by the unmodified data beats, so the external-memory writer sees a self-describing flat word stream. It also keeps packet, word and length-error counters for the register interface.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 256, input data width; only 256 is supported.
- C_M_AXIS_DATA_WIDTH, 256, output data width; must equal C_S_AXIS_DATA_WIDTH.
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width; bits [15:0] are length in bytes, bits [63:32] are the timestamp delta.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  256  packet data.
- s_axis_tkeep  in  32  byte enables, contiguous from bit 0.
- s_axis_tuser  in  128  metadata; sampled on the first beat of a packet only.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of the packet.
- m_axis_tdata  out  256  header word or data beat.
- m_axis_tkeep  out  32  all ones on the header; input tkeep on data beats.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  ready from the memory writer.
- m_axis_tlast  out  1  set on the last data beat only.
- store_en  in  1  enables the start of new packets.
- stat_clear  in  1  synchronous clear of all counters.
- stat_pkt_count  out  32  packets fully forwarded.
- stat_word_count  out  32  output handshakes, header words included.
- stat_len_err_count  out  16  packets whose counted bytes differ from tuser[15:0]; saturates.

## Operation
- Output stage: one register slot holding {tdata, tkeep, tlast} plus a valid bit. The slot is free when m_axis_tvalid=0 or m_axis_tready=1.
- FSM states: IDLE, DATA.
- IDLE:
  - s_axis_tready=0.
  - If s_axis_tvalid & store_en & slot free: load the header into the slot, latch len=s_axis_tuser[15:0], clear the byte accumulator, go to DATA.
  - The first input beat is not consumed in this cycle.
- DATA:
  - s_axis_tready = slot free.
  - On an input handshake: load the beat into the slot and add popcount(s_axis_tkeep) to the byte accumulator.
  - If s_axis_tlast is also set: increment stat_pkt_count, compare (accumulator + this beat's bytes) with the latched len, increment stat_len_err_count if they differ (saturating at 0xFFFF), then go to IDLE.
- store_en is examined only in IDLE. Deasserting it mid-packet lets the current packet complete.
- Header word layout:
  - [15:0] len.
  - [26:16] beats = (len+31)>>5, 11 bits.
  - [31:27] zero.
  - [63:32] s_axis_tuser[63:32].
  - [95:64] stat_pkt_count at header load time.
  - [223:96] zero.
  - [255:224] 32'hCAFE_0001.
- stat_word_count increments on every m_axis handshake.
- stat_clear zeroes all three counters; it does not affect the FSM or the datapath.
  - If stat_clear coincides with an increment, the counter reads 0.
  - If stat_clear occurs mid-packet, the next header carries sequence number 0 only if no tlast is accepted before it.
- All counters wrap at 2^32 except stat_len_err_count.
- Packets with tuser len=0: header beats field is 0; data beats pass unchanged; the error is counted if any bytes are present.

## Timing
- Reset values: state IDLE; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0; s_axis_tready=0; all counters 0.
- Latency:
  - The header appears on m_axis one cycle after the IDLE cycle in which s_axis_tvalid is seen with the slot free.
  - Each data beat appears one cycle after its input handshake.
- Throughput: N+1 output cycles per N-beat packet with no backpressure. Back-to-back packets have no idle gap beyond the header cycle.
- The output holds stable while m_axis_tvalid=1 and m_axis_tready=0. The input is stalled combinationally through s_axis_tready.
- Simultaneous events:
  - Slot drain and refill in the same cycle is allowed: full rate.
  - tlast accepted in the same cycle as a new tvalid: the next header is loaded one cycle later, from IDLE.
- Reset mid-packet clears everything immediately. Upstream shares the reset, so no partial packet survives.

## Test plan
- 60-byte packet, tuser[15:0]=60, tuser[63:32]=0x100, m_axis_tready=1 -> header with [15:0]=60, beats=2, ts=0x100, seq=0, magic 0xCAFE0001; then beat0 with tkeep=0xFFFFFFFF, then beat1 with tkeep=0x0FFFFFFF and tlast=1. Counters: pkt=1, word=3, err=0.
- Same packet with m_axis_tready toggling 1,0,0,1,... -> no beat is lost or duplicated; outputs stay stable while stalled; final word count is 3.
- Three back-to-back 64-byte packets -> 9 output words in 9 consecutive cycles; header sequence numbers are 0, 1, 2.
- tuser len=100 with only 64 bytes delivered -> header beats=4; stat_len_err_count=1; the data passes unmodified.
- store_en=0 with a packet pending -> s_axis_tready=0 and no output. Raising store_en -> header on the next cycle. Dropping store_en mid-packet -> the packet completes.
- stat_clear pulsed after two packets -> all counters read 0; the next header has seq=0. Asserting axis_areset mid-packet -> m_axis_tvalid drops immediately and the FSM returns to IDLE.
